alu_op_issue: RTL and testbench
===============================

Name: alu_op_issue

Overview:
- Decode-side producer of the 4-bit ALU control code consumed by the execute-stage ALU.
- Decodes RV32I opcode, funct3 and funct7 into the ALU opcode, operand-source selects and branch info.
- Registers the decoded bundle into the ID/EX pipeline register, with stall/flush handshake and a valid bit.
- Sits between the decode stage and the execute stage; latency is one clock.

Parameters:
- XLEN, 32, datapath width of the pc and imm pass-through.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- id_valid  in  1  decode slot holds an instruction.
- id_instr  in  32  raw instruction word.
- id_pc  in  XLEN  instruction address.
- id_imm  in  XLEN  sign-extended immediate from the immediate generator.
- stall  in  1  hold the ID/EX register.
- flush  in  1  kill the ID/EX contents (branch mispredict or trap).
- id_ready  out  1  equals ~stall; decode may advance.
- ex_valid  out  1  registered bundle is live.
- ex_alu_ctrl  out  4  ALU opcode.
- ex_src_a_sel  out  2  0=rs1, 1=pc, 2=zero.
- ex_src_b_sel  out  2  0=rs2, 1=imm, 2=constant 4.
- ex_is_branch  out  1  conditional branch.
- ex_branch_f3  out  3  branch funct3 for the compare-result polarity.
- ex_illegal  out  1  illegal instruction (feature-dependent).
- ex_pc  out  XLEN  registered id_pc.
- ex_imm  out  XLEN  registered id_imm.

Behaviour:
- Reset (asynchronous, immediate): every output register is 0. ex_alu_ctrl=ADD(0000), both selects 0, ex_valid=0. id_ready is combinational and not reset.
- ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
- Decode, opcode 0110011 (R-type), src_b=rs2:
  - funct3 000 gives ADD when funct7=0x00, SUB when funct7=0x20.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND require funct7=0x00.
  - 101 gives SRL when funct7=0x00, SRA when funct7=0x20.
  - Any other funct7 is illegal.
- Opcode 0010011 (I-ALU), src_b=imm: same funct3 map with no SUB. funct3 001 requires funct7=0x00. funct3 101 gives SRL for 0x00, SRA for 0x20, anything else is illegal.
- Loads 0000011 and stores 0100011: ADD, src_a=rs1, src_b=imm.
- Branch 1100011: src_b=rs2, ex_is_branch=1.
  - BEQ/BNE (000/001) give SUB.
  - BLT/BGE (100/101) give SLT.
  - BLTU/BGEU (110/111) give SLTU.
  - funct3 010/011 are illegal.
- LUI 0110111: ADD, src_a=zero, src_b=imm.
- AUIPC 0010111: ADD, src_a=pc, src_b=imm.
- JAL 1101111 and JALR 1100111: ADD, src_a=pc, src_b=4 (link value).
- Any other opcode is illegal.
- Register update priority per rising edge:
  - flush: ex_valid<=0, ex_illegal<=0, all other fields hold.
  - else stall: all fields hold.
  - else: load the decoded bundle, ex_valid<=id_valid.
- flush+stall in the same cycle: flush wins.
- id_valid=0 with no stall: load a bubble (ex_valid=0). Other fields load decoded garbage; consumers must qualify on ex_valid.
- An illegal instruction decodes ALU fields as ADD / rs1 / rs2 / not-branch.

Optional Feature:
- Macro ALU_ILLEGAL_TRAP_EN.
- Defined: an illegal instruction loads with ex_valid=id_valid and ex_illegal=1, for the trap logic.
- Undefined: ex_illegal is constant 0. An illegal instruction loads as a bubble (ex_valid=0).

Decomposition:
- Package alu_pkg holds the ALU opcode localparams (shared with the execute ALU), the src_a/src_b select encodings and the RV32I opcode constants.
- One sub-module, alu_op_decode: purely combinational decode of instr to bundle plus illegal flag.
- The top level holds the ID/EX register and the stall/flush logic.

Test Plan:
- Reset: assert rst mid-cycle with ex_valid=1 -> all outputs 0 immediately, with no clock edge required.
- R-type: id_instr=0x40B50533 (sub a0,a0,a1), id_valid=1 -> next edge ex_alu_ctrl=0001, src_b_sel=0, ex_valid=1.
- Shift-imm and branch: 0x40335293 (srai t0,t1,3) -> 0111 with src_b_sel=1. Then 0x00B56463 (bltu a0,a1,8) -> 1001, ex_is_branch=1, ex_branch_f3=110.
- Stall/flush: load LUI 0x123452B7, then assert stall 3 cycles with new instructions on id_instr -> outputs frozen (ADD, src_a=2). Then stall+flush together -> ex_valid=0 and fields unchanged.
- Illegal: 0x0000000B, then 0x40B51533 (SLL with funct7=0x20):
  - with ALU_ILLEGAL_TRAP_EN -> ex_valid=1, ex_illegal=1, ex_alu_ctrl=0000;
  - without -> ex_valid=0, ex_illegal=0.
- Jump: 0x008000EF (jal ra,8) with id_pc=0x100 -> ADD, src_a_sel=1, src_b_sel=2, ex_pc=0x100.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcodes, operand-select encodings and RV32I opcode constants.
// Imported by the decode/issue stage and the execute-stage ALU.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;
  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic [1:0] src_a_sel;
    logic [1:0] src_b_sel;
    logic       is_branch;
    logic [2:0] branch_f3;
  } dec_t;

  // Base funct3 map shared by R-type and I-ALU; funct7 variants are applied by the caller.
  function automatic logic [3:0] funct3_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode of opcode/funct3/funct7 into the ALU bundle and an illegal flag.
// Zero latency; no flow control.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        bundle,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    bundle           = '0;
    bundle.alu_ctrl  = ALU_ADD;
    bundle.src_a_sel = SRC_A_RS1;
    bundle.src_b_sel = SRC_B_RS2;
    illegal          = 1'b0;
    case (opcode)
      OP_R: begin
        bundle.alu_ctrl = funct3_alu(funct3);
        if (funct7 == F7_ALT && funct3 == 3'b000) bundle.alu_ctrl = ALU_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101) bundle.alu_ctrl = ALU_SRA;
        else if (funct7 != F7_BASE) illegal = 1'b1;
      end
      OP_IMM: begin
        bundle.alu_ctrl  = funct3_alu(funct3);
        bundle.src_b_sel = SRC_B_IMM;
        if (funct3 == 3'b001 && funct7 != F7_BASE) illegal = 1'b1;
        if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT) bundle.alu_ctrl = ALU_SRA;
          else if (funct7 != F7_BASE) illegal = 1'b1;
        end
      end
      OP_LOAD, OP_STORE: bundle.src_b_sel = SRC_B_IMM;
      OP_BRANCH: begin
        bundle.is_branch = 1'b1;
        case (funct3)
          3'b000, 3'b001: bundle.alu_ctrl = ALU_SUB;
          3'b100, 3'b101: bundle.alu_ctrl = ALU_SLT;
          3'b110, 3'b111: bundle.alu_ctrl = ALU_SLTU;
          default:        illegal = 1'b1;
        endcase
      end
      OP_LUI: begin
        bundle.src_a_sel = SRC_A_ZERO;
        bundle.src_b_sel = SRC_B_IMM;
      end
      OP_AUIPC: begin
        bundle.src_a_sel = SRC_A_PC;
        bundle.src_b_sel = SRC_B_IMM;
      end
      OP_JAL, OP_JALR: begin
        bundle.src_a_sel = SRC_A_PC;
        bundle.src_b_sel = SRC_B_FOUR;
      end
      default: illegal = 1'b1;
    endcase
    // Illegal encodings collapse to a harmless ADD rs1,rs2 so execute never sees stray controls.
    if (illegal) begin
      bundle.alu_ctrl  = ALU_ADD;
      bundle.src_a_sel = SRC_A_RS1;
      bundle.src_b_sel = SRC_B_RS2;
      bundle.is_branch = 1'b0;
    end
    bundle.branch_f3 = funct3;
  end

endmodule

// File: rtl/alu_op_issue.sv
// ID/EX register for the decoded ALU bundle: one-cycle latency, stall holds, flush kills (flush wins).
// ALU_ILLEGAL_TRAP_EN: illegal instructions issue with ex_illegal=1 instead of becoming bubbles.
module alu_op_issue
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_imm,
  input  logic            stall,
  input  logic            flush,
  output logic            id_ready,
  output logic            ex_valid,
  output logic [3:0]      ex_alu_ctrl,
  output logic [1:0]      ex_src_a_sel,
  output logic [1:0]      ex_src_b_sel,
  output logic            ex_is_branch,
  output logic [2:0]      ex_branch_f3,
  output logic            ex_illegal,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm
);

  dec_t bundle;
  logic illegal;
  logic load_valid;
  logic load_illegal;

  alu_op_decode u_decode (
    .instr   (id_instr),
    .bundle  (bundle),
    .illegal (illegal)
  );

  assign id_ready = ~stall;

`ifdef ALU_ILLEGAL_TRAP_EN
  assign load_valid   = id_valid;
  assign load_illegal = id_valid & illegal;
`else
  assign load_valid   = id_valid & ~illegal;
  assign load_illegal = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_alu_ctrl  <= ALU_ADD;
      ex_src_a_sel <= SRC_A_RS1;
      ex_src_b_sel <= SRC_B_RS2;
      ex_is_branch <= 1'b0;
      ex_branch_f3 <= 3'b000;
      ex_illegal   <= 1'b0;
      ex_pc        <= '0;
      ex_imm       <= '0;
    end else if (flush) begin
      ex_valid   <= 1'b0;
      ex_illegal <= 1'b0;
    end else if (!stall) begin
      // Payload loads even for bubbles; consumers qualify on ex_valid.
      ex_valid     <= load_valid;
      ex_illegal   <= load_illegal;
      ex_alu_ctrl  <= bundle.alu_ctrl;
      ex_src_a_sel <= bundle.src_a_sel;
      ex_src_b_sel <= bundle.src_b_sel;
      ex_is_branch <= bundle.is_branch;
      ex_branch_f3 <= bundle.branch_f3;
      ex_pc        <= id_pc;
      ex_imm       <= id_imm;
    end
  end

endmodule

// File: tb/tb_alu_op_issue.sv
// Self-checking bench for alu_op_issue: directed cases with literal expectations plus
// randomized traffic compared every cycle against a behavioural ID/EX model.
module tb_alu_op_issue;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_imm;
  logic            stall;
  logic            flush;
  logic            id_ready;
  logic            ex_valid;
  logic [3:0]      ex_alu_ctrl;
  logic [1:0]      ex_src_a_sel;
  logic [1:0]      ex_src_b_sel;
  logic            ex_is_branch;
  logic [2:0]      ex_branch_f3;
  logic            ex_illegal;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;

  int n_checks = 0;
  int n_fail   = 0;

  alu_op_issue #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_imm       (id_imm),
    .stall        (stall),
    .flush        (flush),
    .id_ready     (id_ready),
    .ex_valid     (ex_valid),
    .ex_alu_ctrl  (ex_alu_ctrl),
    .ex_src_a_sel (ex_src_a_sel),
    .ex_src_b_sel (ex_src_b_sel),
    .ex_is_branch (ex_is_branch),
    .ex_branch_f3 (ex_branch_f3),
    .ex_illegal   (ex_illegal),
    .ex_pc        (ex_pc),
    .ex_imm       (ex_imm)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode written from the instruction-set rules, not the RTL structure.
  function automatic void ref_decode(input logic [31:0] ins, output logic [3:0] alu,
                                     output logic [1:0] a, output logic [1:0] b,
                                     output logic br, output logic ill);
    logic [3:0] base_map [8];
    logic [6:0] op;
    int f3;
    int f7;
    base_map = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    op = ins[6:0];
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    alu = 4'd0; a = 2'd0; b = 2'd0; br = 1'b0; ill = 1'b0;
    if (op == 7'h33) begin
      alu = base_map[f3];
      if (f7 == 32 && (f3 == 0 || f3 == 5)) alu = alu + 4'd1;
      else if (f7 != 0) ill = 1'b1;
    end else if (op == 7'h13) begin
      b = 2'd1;
      alu = base_map[f3];
      if (f3 == 1 && f7 != 0) ill = 1'b1;
      if (f3 == 5 && f7 == 32) alu = 4'd7;
      else if (f3 == 5 && f7 != 0) ill = 1'b1;
    end else if (op == 7'h03 || op == 7'h23) begin
      b = 2'd1;
    end else if (op == 7'h63) begin
      br = 1'b1;
      if (f3 == 2 || f3 == 3) ill = 1'b1;
      else if (f3 < 2) alu = 4'd1;
      else if (f3 < 6) alu = 4'd8;
      else alu = 4'd9;
    end else if (op == 7'h37) begin
      a = 2'd2; b = 2'd1;
    end else if (op == 7'h17) begin
      a = 2'd1; b = 2'd1;
    end else if (op == 7'h6F || op == 7'h67) begin
      a = 2'd1; b = 2'd2;
    end else begin
      ill = 1'b1;
    end
    if (ill) begin
      alu = 4'd0; a = 2'd0; b = 2'd0; br = 1'b0;
    end
  endfunction

  // Behavioural ID/EX register state.
  logic            m_valid, m_br, m_ill;
  logic [3:0]      m_alu;
  logic [1:0]      m_a, m_b;
  logic [2:0]      m_f3;
  logic [XLEN-1:0] m_pc, m_imm;

  always @(posedge clk or posedge rst) begin
    logic [3:0] d_alu;
    logic [1:0] d_a, d_b;
    logic d_br, d_ill;
    if (rst) begin
      {m_valid, m_br, m_ill, m_alu, m_a, m_b, m_f3, m_pc, m_imm} = '0;
    end else if (flush) begin
      m_valid = 1'b0;
      m_ill   = 1'b0;
    end else if (!stall) begin
      ref_decode(id_instr, d_alu, d_a, d_b, d_br, d_ill);
      m_alu = d_alu; m_a = d_a; m_b = d_b; m_br = d_br;
      m_f3  = id_instr[14:12];
      m_pc  = id_pc;
      m_imm = id_imm;
`ifdef ALU_ILLEGAL_TRAP_EN
      m_valid = id_valid;
      m_ill   = id_valid & d_ill;
`else
      m_valid = id_valid & ~d_ill;
      m_ill   = 1'b0;
`endif
    end
  end

  function automatic logic [127:0] dut_vec();
    return {50'd0, ex_valid, ex_alu_ctrl, ex_src_a_sel, ex_src_b_sel, ex_is_branch,
            ex_branch_f3, ex_illegal, ex_pc, ex_imm};
  endfunction

  function automatic logic [127:0] model_vec();
    return {50'd0, m_valid, m_alu, m_a, m_b, m_br, m_f3, m_ill, m_pc, m_imm};
  endfunction

  always @(negedge clk) begin
    check("model_outputs", dut_vec(), model_vec());
    check("id_ready", {127'd0, id_ready}, {127'd0, ~stall});
  end

  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] imm,
                      input logic v, input logic st, input logic fl);
    id_instr = ins; id_pc = pc; id_imm = imm; id_valid = v; stall = st; flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_instr = '0; id_pc = '0; id_imm = '0;
    stall = 1'b0; flush = 1'b0;
    #2;
    check("reset_outputs", dut_vec(), 128'd0);
    #10 rst = 1'b0;

    step(32'h40B50533, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0);
    check("sub_alu", {124'd0, ex_alu_ctrl}, 128'd1);
    check("sub_srcb", {126'd0, ex_src_b_sel}, 128'd0);
    check("sub_valid", {127'd0, ex_valid}, 128'd1);

    #2 rst = 1'b1;
    #1;
    check("async_reset_valid", {127'd0, ex_valid}, 128'd0);
    check("async_reset_all", dut_vec(), 128'd0);
    @(negedge clk);
    #1 rst = 1'b0;

    step(32'h40335293, 32'h44, 32'h3, 1'b1, 1'b0, 1'b0);
    check("srai_alu", {124'd0, ex_alu_ctrl}, 128'd7);
    check("srai_srcb", {126'd0, ex_src_b_sel}, 128'd1);
    step(32'h00B56463, 32'h48, 32'h8, 1'b1, 1'b0, 1'b0);
    check("bltu_alu", {124'd0, ex_alu_ctrl}, 128'd9);
    check("bltu_branch", {127'd0, ex_is_branch}, 128'd1);
    check("bltu_f3", {125'd0, ex_branch_f3}, 128'd6);

    step(32'h123452B7, 32'h4C, 32'h12345000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(32'h40B50533 + 32'(i), 32'h50 + 32'(4 * i), 32'h0, 1'b1, 1'b1, 1'b0);
      check("stall_alu", {124'd0, ex_alu_ctrl}, 128'd0);
      check("stall_srca", {126'd0, ex_src_a_sel}, 128'd2);
      check("stall_valid", {127'd0, ex_valid}, 128'd1);
      check("stall_imm", {96'd0, ex_imm}, 128'h12345000);
    end
    step(32'h00B56463, 32'h60, 32'h0, 1'b1, 1'b1, 1'b1);
    check("flush_valid", {127'd0, ex_valid}, 128'd0);
    check("flush_srca", {126'd0, ex_src_a_sel}, 128'd2);
    check("flush_pc", {96'd0, ex_pc}, 128'h4C);

    step(32'h0000000B, 32'h64, 32'h0, 1'b1, 1'b0, 1'b0);
`ifdef ALU_ILLEGAL_TRAP_EN
    check("illop_valid", {126'd0, ex_valid, ex_illegal}, 128'd3);
`else
    check("illop_valid", {126'd0, ex_valid, ex_illegal}, 128'd0);
`endif
    check("illop_alu", {124'd0, ex_alu_ctrl}, 128'd0);
    step(32'h40B51533, 32'h68, 32'h0, 1'b1, 1'b0, 1'b0);
`ifdef ALU_ILLEGAL_TRAP_EN
    check("illsll_valid", {126'd0, ex_valid, ex_illegal}, 128'd3);
`else
    check("illsll_valid", {126'd0, ex_valid, ex_illegal}, 128'd0);
`endif
    check("illsll_alu", {124'd0, ex_alu_ctrl}, 128'd0);

    step(32'h008000EF, 32'h100, 32'h8, 1'b1, 1'b0, 1'b0);
    check("jal_alu", {124'd0, ex_alu_ctrl}, 128'd0);
    check("jal_sel", {124'd0, ex_src_a_sel, ex_src_b_sel}, 128'h6);
    check("jal_pc", {96'd0, ex_pc}, 128'h100);
    check("jal_valid", {127'd0, ex_valid}, 128'd1);

    for (int i = 0; i < 3000; i++) begin
      logic [6:0] ops [10];
      logic [6:0] f7;
      logic [31:0] ins;
      int r;
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h0B};
      r = int'($urandom_range(0, 3));
      f7 = (r == 0) ? 7'h00 : (r == 1) ? 7'h20 : 7'($urandom);
      ins = {f7, 18'($urandom), ops[$urandom_range(0, 9)]};
      if ($urandom_range(0, 15) == 0) ins = $urandom;
      step(ins, $urandom, $urandom, ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
